// File: rtl/mash_pkg.sv
// Shared defaults and helpers for the MASH 1-1 delta-sigma modulator.
package mash_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int DAC_BW_DEF = 4;

    // Fractional width carried by the accumulators; one bit wider than the dropped LSBs
    // because the integer field gives up its top bit to make headroom for the shaping term.
    function automatic int frac_w(input int width, input int dac_bw);
        return width - dac_bw + 1;
    endfunction

    typedef logic signed [DAC_BW_DEF-1:0] dac_code_t;

endpackage

// File: rtl/mash_acc_stage.sv
// Enable-gated wrapping accumulator; sum and carry are combinational from the held value.
module mash_acc_stage #(
    parameter int W = 13
) (
    input  logic         clk_sys,
    input  logic         rst_b,
    input  logic         en,
    input  logic [W-1:0] addend,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] acc;

    assign {carry, sum} = {1'b0, acc} + {1'b0, addend};

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/mash11_modulator.sv
// Second-order MASH 1-1 requantizer: WIDTH-bit signed samples to DAC_BW-bit signed codes.
module mash11_modulator
    import mash_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DAC_BW = DAC_BW_DEF
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic [WIDTH-1:0]  s_axis_data_tdata,
    input  logic              s_axis_data_tvalid,
    output logic              s_axis_data_tready,
    output logic [DAC_BW-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tvalid
);

    localparam int FRAC_W = frac_w(WIDTH, DAC_BW);

    logic [DAC_BW-2:0] int_part;
    logic [FRAC_W-1:0] frac_part;
    logic              accept;
    logic [FRAC_W-1:0] s1;
    logic [FRAC_W-1:0] s2;
    logic              c1;
    logic              c2;
    logic              c2_d;
    logic [DAC_BW-1:0] int_ext;
    logic [DAC_BW-1:0] y;

    assign int_part  = s_axis_data_tdata[WIDTH-1 -: DAC_BW-1];
    assign frac_part = s_axis_data_tdata[FRAC_W-1:0];
    assign accept    = s_axis_data_tvalid & s_axis_data_tready;

    mash_acc_stage #(.W(FRAC_W)) u_stage1 (
        .clk_sys (aclk),
        .rst_b   (arst_n),
        .en      (accept),
        .addend  (frac_part),
        .sum     (s1),
        .carry   (c1)
    );

    // Stage 2 integrates the fresh stage-1 sum, so both carries belong to the same sample.
    mash_acc_stage #(.W(FRAC_W)) u_stage2 (
        .clk_sys (aclk),
        .rst_b   (arst_n),
        .en      (accept),
        .addend  (s1),
        .sum     (s2),
        .carry   (c2)
    );

    // Modular DAC_BW-bit arithmetic is exact: the result always lies in int-1..int+2.
    assign int_ext = {int_part[DAC_BW-2], int_part};
    assign y = int_ext
             + {{(DAC_BW-1){1'b0}}, c1}
             + {{(DAC_BW-1){1'b0}}, c2}
             - {{(DAC_BW-1){1'b0}}, c2_d};

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            c2_d               <= 1'b0;
            m_axis_data_tdata  <= '0;
            m_axis_data_tvalid <= 1'b0;
            s_axis_data_tready <= 1'b0;
        end else begin
            s_axis_data_tready <= 1'b1;
            m_axis_data_tvalid <= accept;
            if (accept) begin
                c2_d              <= c2;
                m_axis_data_tdata <= y;
            end
        end
    end

endmodule

// File: tb/tb_mash11_modulator.sv
// Scoreboard bench for mash11_modulator against an arithmetic MASH 1-1 reference model.
module tb_mash11_modulator;

    localparam int WIDTH  = 16;
    localparam int DAC_BW = 4;
    localparam int FRAC_W = WIDTH - DAC_BW + 1;
    localparam int MODV   = 1 << FRAC_W;

    logic              aclk = 1'b0;
    logic              arst_n;
    logic [WIDTH-1:0]  s_axis_data_tdata;
    logic              s_axis_data_tvalid;
    logic              s_axis_data_tready;
    logic [DAC_BW-1:0] m_axis_data_tdata;
    logic              m_axis_data_tvalid;

    mash11_modulator #(.WIDTH(WIDTH), .DAC_BW(DAC_BW)) dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .s_axis_data_tdata  (s_axis_data_tdata),
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .s_axis_data_tready (s_axis_data_tready),
        .m_axis_data_tdata  (m_axis_data_tdata),
        .m_axis_data_tvalid (m_axis_data_tvalid)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    int m_a1 = 0, m_a2 = 0, m_c2d = 0;
    bit exp_tready = 0, exp_valid = 0, exp_rst = 1, mon_en = 0;
    int exp_q[$];
    int log_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: two wrapping fractional accumulators; output = integer part plus
    // first carry plus the first difference of the second carry.
    function automatic int model_sample(input logic [WIDTH-1:0] x);
        int xi, ip, fr, c1, c2, y;
        xi = int'($signed(x));
        ip = xi >>> FRAC_W;
        fr = xi & (MODV - 1);
        m_a1 = m_a1 + fr;
        c1 = (m_a1 >= MODV) ? 1 : 0;
        m_a1 = m_a1 % MODV;
        m_a2 = m_a2 + m_a1;
        c2 = (m_a2 >= MODV) ? 1 : 0;
        m_a2 = m_a2 % MODV;
        y = ip + c1 + c2 - m_c2d;
        m_c2d = c2;
        return y;
    endfunction

    task automatic step(input logic rst_n, input logic vld, input logic [WIDTH-1:0] x);
        bit acc;
        arst_n = rst_n;
        s_axis_data_tvalid = vld;
        s_axis_data_tdata = x;
        @(posedge aclk);
        #1;
        if (!rst_n) begin
            m_a1 = 0; m_a2 = 0; m_c2d = 0;
            exp_valid = 0; exp_tready = 0; exp_rst = 1;
            exp_q.delete();
        end else begin
            acc = vld && exp_tready;
            if (acc) exp_q.push_back(model_sample(x));
            exp_valid = acc;
            exp_tready = 1;
            exp_rst = 0;
        end
        mon_en = 1;
    endtask

    task automatic settle();
        @(negedge aclk);
        #1;
    endtask

    task automatic reset_release();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 16'h1000);
        step(1'b1, 1'b0, 16'h0000);
    endtask

    // Monitor: checks handshake outputs every cycle and pops the scoreboard on each valid code.
    initial begin
        int exp;
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                check("s_tready", int'(s_axis_data_tready), int'(exp_tready));
                check("m_tvalid", int'(m_axis_data_tvalid), int'(exp_valid));
                if (exp_rst) check("m_tdata_reset", int'($signed(m_axis_data_tdata)), 0);
                if (m_axis_data_tvalid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("m_tdata", int'($signed(m_axis_data_tdata)), exp);
                    end
                    log_q.push_back(int'($signed(m_axis_data_tdata)));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sum, mn, mx;
        int pat[4] = '{0, 1, 1, 0};
        logic [WIDTH-1:0] x;

        arst_n = 1'b0; s_axis_data_tvalid = 1'b1; s_axis_data_tdata = '0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h2000);
        step(1'b1, 1'b1, 16'h0000);
        settle();

        log_q.delete();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'h0000);
        settle();
        check("zero_count", log_q.size(), 20);
        foreach (log_q[i]) check("zero_code", log_q[i], 0);

        log_q.delete();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 16'h2000);
        settle();
        foreach (log_q[i]) check("plus1_code", log_q[i], 1);
        log_q.delete();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 16'h8000);
        settle();
        foreach (log_q[i]) check("minus4_code", log_q[i], -4);

        reset_release();
        settle();
        log_q.delete();
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 16'h1000);
        settle();
        sum = 0;
        foreach (log_q[i]) begin
            sum += log_q[i];
            check("half_pattern", log_q[i], pat[i % 4]);
        end
        check("half_sum64", sum, 32);

        log_q.delete();
        sum = 0; mn = 100; mx = -100;
        for (int i = 0; i < 1024; i++) step(1'b1, 1'b1, 16'h7FFF);
        settle();
        foreach (log_q[i]) begin
            sum += log_q[i];
            if (log_q[i] < mn) mn = log_q[i];
            if (log_q[i] > mx) mx = log_q[i];
        end
        check("max_count", log_q.size(), 1024);
        check("max_range", int'(mn >= 2 && mx <= 5), 1);
        check("max_mean", int'(sum * 100 > 399 * 1024), 1);

        log_q.delete();
        mn = 100; mx = -100;
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 16'hE000);
        settle();
        foreach (log_q[i]) begin
            if (log_q[i] < mn) mn = log_q[i];
            if (log_q[i] > mx) mx = log_q[i];
        end
        check("neg_range", int'(mn >= -2 && mx <= 1), 1);

        reset_release();
        settle();
        log_q.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 16'h1000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h1000);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 16'h1000);
        settle();
        check("gap_count", log_q.size(), 16);
        foreach (log_q[i]) check("gap_pattern", log_q[i], pat[i % 4]);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'h1000);
        reset_release();
        settle();
        log_q.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'h1000);
        settle();
        check("rst_count", log_q.size(), 8);
        foreach (log_q[i]) check("rst_pattern", log_q[i], pat[i % 4]);

        for (int i = 0; i < 400; i++) begin
            x = WIDTH'($urandom);
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), x);
        end
        step(1'b1, 1'b0, 16'h0000);
        settle();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
